// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and encodings for the program-counter sequencer
package pc_pkg;

  typedef enum logic {
    PC_RUN     = 1'b0,
    PC_HANDLER = 1'b1
  } pc_state_e;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - execute-stage to PC-sequencer signal bundle
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  stall;
  logic                  branch_stmt;
  logic [2:0]            funct3;
  logic                  zero;
  logic                  Less_than;
  logic                  Less_than_unsigned;
  logic                  jump;
  logic [31:0]           immediate;
  logic [31:0]           ALU_result;
  logic                  trap_req;
  logic [3:0]            trap_cause;
  logic                  mret;
  logic [ADDR_WIDTH-1:0] PC;
  logic [ADDR_WIDTH-1:0] pc_plus_four;
  logic [ADDR_WIDTH-1:0] mepc;
  logic [3:0]            mcause;
  logic                  in_handler;
  logic                  flush;

  modport master (
    output stall, branch_stmt, funct3, zero, Less_than, Less_than_unsigned,
           jump, immediate, ALU_result, trap_req, trap_cause, mret,
    input  PC, pc_plus_four, mepc, mcause, in_handler, flush
  );

  modport slave (
    input  stall, branch_stmt, funct3, zero, Less_than, Less_than_unsigned,
           jump, immediate, ALU_result, trap_req, trap_cause, mret,
    output PC, pc_plus_four, mepc, mcause, in_handler, flush
  );

endinterface

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - funct3 + comparator flags to branch-taken decision
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       Less_than,
  input  logic       Less_than_unsigned,
  output logic       branch_success
);

  always_comb begin
    branch_success = 1'b0;
    case (funct3)
      F3_BEQ:  branch_success = zero;
      F3_BNE:  branch_success = ~zero;
      F3_BLT:  branch_success = Less_than;
      F3_BGE:  branch_success = ~Less_than;
      F3_BLTU: branch_success = Less_than_unsigned;
      F3_BGEU: branch_success = ~Less_than_unsigned;
      default: branch_success = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC, branch/jump redirect, machine-mode trap and mret
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] TRAP_VEC   = ADDR_WIDTH'(32'h0000_0100),
  parameter bit                    C_EXT      = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mepc_q, mepc_d;
  logic [3:0]            mcause_q, mcause_d;
  pc_state_e             state_q, state_d;
  logic                  flush_q, flush_d;

  logic                  branch_success;
  logic                  branch_taken;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] branch_tgt;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic                  misaligned;

  branch_cond u_branch_cond (
    .funct3             (bus.funct3),
    .zero               (bus.zero),
    .Less_than          (bus.Less_than),
    .Less_than_unsigned (bus.Less_than_unsigned),
    .branch_success     (branch_success)
  );

  always_comb begin
    branch_taken = bus.branch_stmt & branch_success;
    branch_tgt   = pc_q + bus.immediate[ADDR_WIDTH-1:0];
    jump_tgt     = bus.ALU_result[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(1);
    redirect     = bus.jump | branch_taken;
    redirect_tgt = bus.jump ? jump_tgt : branch_tgt;
    // With compressed instructions any even target is legal.
    misaligned   = redirect & ~C_EXT & redirect_tgt[1];
  end

  always_comb begin
    pc_d     = pc_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    state_d  = state_q;
    flush_d  = flush_q;
    if (!bus.stall) begin
      flush_d = 1'b1;
      if (bus.trap_req || misaligned || (bus.mret && state_q == PC_RUN)) begin
        pc_d    = TRAP_VEC;
        mepc_d  = pc_q;
        state_d = PC_HANDLER;
        if (bus.trap_req) begin
          mcause_d = bus.trap_cause;
        end else if (misaligned) begin
          mcause_d = CAUSE_MISALIGN;
        end else begin
          mcause_d = CAUSE_ILLEGAL;
        end
      end else if (bus.mret) begin
        pc_d    = mepc_q;
        state_d = PC_RUN;
      end else if (redirect) begin
        pc_d = redirect_tgt;
      end else begin
        pc_d    = pc_q + ADDR_WIDTH'(4);
        flush_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_ADDR;
      mepc_q   <= '0;
      mcause_q <= '0;
      state_q  <= PC_RUN;
      flush_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      state_q  <= state_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.pc_plus_four = pc_q + ADDR_WIDTH'(4);
  assign bus.mepc         = mepc_q;
  assign bus.mcause       = mcause_q;
  assign bus.in_handler   = (state_q == PC_HANDLER);
  assign bus.flush        = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst0, rst1;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_WIDTH(32)) bus0 ();
  pc_sequencer_if #(.ADDR_WIDTH(32)) bus1 ();

  pc_sequencer #(
    .ADDR_WIDTH (32),
    .RESET_ADDR (32'h0000_1000),
    .TRAP_VEC   (32'h0000_0100),
    .C_EXT      (1'b0)
  ) dut (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0.slave)
  );

  pc_sequencer #(
    .ADDR_WIDTH (32),
    .RESET_ADDR (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .C_EXT      (1'b1)
  ) dut_c (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [2:0]  f3;
    logic [2:0]  flags;
    logic        jmp;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        trq;
    logic [3:0]  cause;
    logic        mret;
    logic [31:0] e_pc;
    logic [31:0] e_mepc;
    logic [3:0]  e_mcause;
    logic        e_ih;
    logic        e_fl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, stl, br, input logic [2:0] f3, flags,
                     input logic jmp, input logic [31:0] imm, alu,
                     input logic trq, input logic [3:0] cause, input logic mret,
                     input logic [31:0] e_pc, e_mepc, input logic [3:0] e_mcause,
                     input logic e_ih, e_fl);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.f3 = f3; v.flags = flags;
    v.jmp = jmp; v.imm = imm; v.alu = alu; v.trq = trq; v.cause = cause;
    v.mret = mret; v.e_pc = e_pc; v.e_mepc = e_mepc; v.e_mcause = e_mcause;
    v.e_ih = e_ih; v.e_fl = e_fl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
      n_miss++;
    end
  endtask

  task automatic drive0(input vec_t v);
    rst0                    = v.rst;
    bus0.stall              = v.stl;
    bus0.branch_stmt        = v.br;
    bus0.funct3             = v.f3;
    bus0.zero               = v.flags[2];
    bus0.Less_than          = v.flags[1];
    bus0.Less_than_unsigned = v.flags[0];
    bus0.jump               = v.jmp;
    bus0.immediate          = v.imm;
    bus0.ALU_result         = v.alu;
    bus0.trap_req           = v.trq;
    bus0.trap_cause         = v.cause;
    bus0.mret               = v.mret;
  endtask

  task automatic drive1(input logic rst, br, input logic [2:0] f3,
                        input logic z, jmp, input logic [31:0] imm, alu);
    rst1                    = rst;
    bus1.stall              = 1'b0;
    bus1.branch_stmt        = br;
    bus1.funct3             = f3;
    bus1.zero               = z;
    bus1.Less_than          = 1'b0;
    bus1.Less_than_unsigned = 1'b0;
    bus1.jump               = jmp;
    bus1.immediate          = imm;
    bus1.ALU_result         = alu;
    bus1.trap_req           = 1'b0;
    bus1.trap_cause         = 4'd0;
    bus1.mret               = 1'b0;
  endtask

  task automatic step1(input string nm, input logic [31:0] e_pc,
                       input logic e_ih, e_fl);
    @(posedge clk);
    #1;
    n_vec++;
    chk({nm, ".pc"}, bus1.PC, e_pc);
    chk({nm, ".ppf"}, bus1.pc_plus_four, e_pc + 32'd4);
    chk({nm, ".ih"}, {31'd0, bus1.in_handler}, {31'd0, e_ih});
    chk({nm, ".fl"}, {31'd0, bus1.flush}, {31'd0, e_fl});
    @(negedge clk);
  endtask

  initial begin
    //  rst stl br f3      {z,lt,ltu} jmp imm            alu            trq cause mret   PC             mepc      mcause ih fl
    add(1, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0000_1000, 32'h0,    4'd0,  0, 0);
    add(1, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0000_1000, 32'h0,    4'd0,  0, 0);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0000_1004, 32'h0,    4'd0,  0, 0);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0000_1008, 32'h0,    4'd0,  0, 0);
    add(0, 0, 0, 3'b000, 3'b000, 1, 32'h0,         32'h20,        0, 4'd0,  0, 32'h20,        32'h0,    4'd0,  0, 1);
    add(0, 0, 1, 3'b000, 3'b100, 0, 32'hFFFF_FFF0, 32'h0,         0, 4'd0,  0, 32'h10,        32'h0,    4'd0,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h14,        32'h0,    4'd0,  0, 0);
    add(0, 0, 1, 3'b101, 3'b010, 0, 32'h40,        32'h0,         0, 4'd0,  0, 32'h18,        32'h0,    4'd0,  0, 0);
    add(0, 0, 1, 3'b001, 3'b000, 0, 32'h8,         32'h0,         0, 4'd0,  0, 32'h20,        32'h0,    4'd0,  0, 1);
    add(0, 0, 1, 3'b010, 3'b111, 0, 32'h40,        32'h0,         0, 4'd0,  0, 32'h24,        32'h0,    4'd0,  0, 0);
    add(0, 0, 1, 3'b110, 3'b001, 0, 32'h1C,        32'h0,         0, 4'd0,  0, 32'h40,        32'h0,    4'd0,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 1, 32'h0,         32'h300,       1, 4'd11, 0, 32'h100,       32'h40,   4'd11, 1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h104,       32'h40,   4'd11, 1, 0);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         1, 4'd5,  0, 32'h100,       32'h104,  4'd5,  1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  1, 32'h104,       32'h104,  4'd5,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 1, 32'h0,         32'h80,        0, 4'd0,  0, 32'h80,        32'h104,  4'd5,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  1, 32'h100,       32'h80,   4'd2,  1, 1);
    add(0, 1, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         1, 4'd7,  0, 32'h100,       32'h80,   4'd2,  1, 1);
    add(0, 1, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         1, 4'd7,  0, 32'h100,       32'h80,   4'd2,  1, 1);
    add(0, 1, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         1, 4'd7,  0, 32'h100,       32'h80,   4'd2,  1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         1, 4'd7,  0, 32'h100,       32'h100,  4'd7,  1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  1, 32'h100,       32'h100,  4'd7,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 1, 32'h0,         32'h203,       0, 4'd0,  0, 32'h100,       32'h100,  4'd0,  1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  1, 32'h100,       32'h100,  4'd0,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 1, 32'h0,         32'hFFFF_FFFD, 0, 4'd0,  0, 32'hFFFF_FFFC, 32'h100,  4'd0,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0,         32'h100,  4'd0,  0, 0);
    add(0, 0, 1, 3'b100, 3'b010, 0, 32'h6,         32'h0,         0, 4'd0,  0, 32'h100,       32'h0,    4'd0,  1, 1);
    add(1, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h0000_1000, 32'h0,    4'd0,  0, 0);
    add(0, 0, 1, 3'b000, 3'b100, 0, 32'hFFFF_F000, 32'h0,         0, 4'd0,  0, 32'h0,         32'h0,    4'd0,  0, 1);
    add(0, 1, 0, 3'b000, 3'b000, 1, 32'h0,         32'h500,       0, 4'd0,  0, 32'h0,         32'h0,    4'd0,  0, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 32'h0,         32'h0,         0, 4'd0,  0, 32'h4,         32'h0,    4'd0,  0, 0);
    add(0, 0, 1, 3'b111, 3'b000, 0, 32'h10,        32'h0,         0, 4'd0,  0, 32'h14,        32'h0,    4'd0,  0, 1);
    add(0, 0, 1, 3'b110, 3'b000, 0, 32'h10,        32'h0,         0, 4'd0,  0, 32'h18,        32'h0,    4'd0,  0, 0);

    drive1(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    drive0(vecs[0]);
    @(negedge clk);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      drive0(vecs[i]);
      @(posedge clk);
      #1;
      n_vec++;
      chk({nm, ".pc"}, bus0.PC, vecs[i].e_pc);
      chk({nm, ".ppf"}, bus0.pc_plus_four, vecs[i].e_pc + 32'd4);
      chk({nm, ".mepc"}, bus0.mepc, vecs[i].e_mepc);
      chk({nm, ".mcause"}, {28'd0, bus0.mcause}, {28'd0, vecs[i].e_mcause});
      chk({nm, ".ih"}, {31'd0, bus0.in_handler}, {31'd0, vecs[i].e_ih});
      chk({nm, ".fl"}, {31'd0, bus0.flush}, {31'd0, vecs[i].e_fl});
      @(negedge clk);
    end

    // Compressed-alignment instance: odd jump target is rounded down, 2-aligned targets accepted.
    drive1(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    step1("c.rst", 32'h0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0, 32'h203);
    step1("c.jalr", 32'h202, 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    step1("c.seq", 32'h206, 1'b0, 1'b0);
    drive1(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 32'h2, 32'h0);
    step1("c.beq2", 32'h208, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
